// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one multi-cycle ALU.
// Define ALU_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES.
module alu_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_result,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_result,
  output logic        rsp1_err,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic        owner;
  logic        last_grant;
  logic        grant_sel;
  logic        accept;
  logic        sel_legal;
  logic        done_hit;
  logic        timed_out;
  logic        in_alu_phase;
  logic [2:0]  sel_op;
  logic [7:0]  sel_a;
  logic [7:0]  sel_b;
  logic [2:0]  op_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] result_q;
  logic        err_q;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("alu_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  // Under contention the requester not granted last wins; a lone requester always wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = req1_valid;
    end
    sel_op    = grant_sel ? req1_op : req0_op;
    sel_a     = grant_sel ? req1_a  : req0_a;
    sel_b     = grant_sel ? req1_b  : req0_b;
    sel_legal = (sel_op <= OP_MUL);
  end

  assign done_hit = (state == WAIT) && alu_done;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts completed WAIT cycles; the last allowed cycle without done forces an error response.
  always_ff @(posedge clk) begin
    if (reset || (state != WAIT)) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timed_out = (state == WAIT) && !alu_done && (wait_cnt == WAIT_LAST);
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    in_alu_phase = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if ((req0_valid || req1_valid) && !reset) begin
          accept     = 1'b1;
          state_next = sel_legal ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        in_alu_phase = 1'b1;
        state_next   = (op_q == OP_NOP) ? RESP : WAIT;
      end
      WAIT: begin
        in_alu_phase = 1'b1;
        if (done_hit || timed_out) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    req0_ready  = accept && !grant_sel;
    req1_ready  = accept && grant_sel;
    alu_start   = in_alu_phase;
    alu_op      = in_alu_phase ? op_q : 3'b000;
    alu_a       = in_alu_phase ? a_q  : 8'h00;
    alu_b       = in_alu_phase ? b_q  : 8'h00;
    rsp0_valid  = (state == RESP) && !owner;
    rsp1_valid  = (state == RESP) && owner;
    rsp0_result = rsp0_valid ? result_q : 16'h0000;
    rsp1_result = rsp1_valid ? result_q : 16'h0000;
    rsp0_err    = rsp0_valid && err_q;
    rsp1_err    = rsp1_valid && err_q;
  end

  // Result/err default to the illegal or no_op outcome at acceptance and are overwritten by the ALU.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= 3'b000;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      result_q   <= 16'h0000;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= grant_sel;
        last_grant <= grant_sel;
        op_q       <= sel_op;
        a_q        <= sel_a;
        b_q        <= sel_b;
        result_q   <= 16'h0000;
        err_q      <= !sel_legal;
      end
      if (done_hit) begin
        result_q <= alu_result;
        err_q    <= 1'b0;
      end else if (timed_out) begin
        result_q <= 16'h0000;
        err_q    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter; the bench also plays the ALU.
// Expected results come from the opcode arithmetic and a round-robin grant history.
module tb_alu_arbiter;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TO = 4;
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam int TO = 64;
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = 3'd0, req1_op = 3'd0;
  logic [7:0]  req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
  logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [15:0] rsp0_result, rsp1_result;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0000;
  logic        busy;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  logic        pend [2];
  logic [2:0]  pOp  [2];
  logic [7:0]  pA   [2];
  logic [7:0]  pB   [2];
  int          lastWinner;
  int          lastW;
  logic [15:0] lastRes;
  logic        lastErr;

  alu_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] refResult(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    case (op)
      3'd1:    return {8'h00, a} + {8'h00, b};
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return {8'h00, a} * {8'h00, b};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus();
    req0_valid = pend[0];
    req0_op    = pOp[0];
    req0_a     = pA[0];
    req0_b     = pB[0];
    req1_valid = pend[1];
    req1_op    = pOp[1];
    req1_a     = pA[1];
    req1_b     = pB[1];
    #1;
  endtask

  task automatic setReq(input int i, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b);
    pend[i] = 1'b1;
    pOp[i]  = op;
    pA[i]   = a;
    pB[i]   = b;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {busy, alu_start, alu_op, alu_a, alu_b, req0_ready, req1_ready,
                      rsp0_valid, rsp0_result, rsp0_err, rsp1_valid, rsp1_result, rsp1_err},
                64'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    alu_done = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    applyStimulus();
    tick();
    checkAllZero("reset_outputs");
    reset = 1'b0;
    lastWinner = 1;
    #1;
  endtask

  // One complete command from IDLE through RESP back to IDLE; doneWait is the WAIT cycle
  // on which the bench raises alu_done, spurious pulses alu_done during ISSUE.
  task automatic runTxn(input int doneWait, input bit spurious);
    int w;
    int waitCycles;
    bit legal;
    bit timeoutCase;
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic [15:0] expRes;
    logic        expErr;
    applyStimulus();
    if (pend[0] && pend[1]) w = 1 - lastWinner;
    else w = pend[1] ? 1 : 0;
    checkOutput("accept_ready", {req1_ready, req0_ready}, (w == 1) ? 2'b10 : 2'b01);
    op = pOp[w];
    a = pA[w];
    b = pB[w];
    lastWinner = w;
    legal = (op <= 3'd4);
    timeoutCase = TIMEOUT_ON && legal && (op != 3'd0) && (doneWait > TO);
    expErr = !legal || timeoutCase;
    expRes = expErr ? 16'h0000 : refResult(op, a, b);
    tick();
    pend[w] = 1'b0;
    applyStimulus();
    checkOutput("post_accept_ready", {req1_ready, req0_ready}, 2'b00);
    if (legal) begin
      checkOutput("issue_cmd", {alu_start, alu_op, alu_a, alu_b}, {1'b1, op, a, b});
      if (op != 3'd0) begin
        if (spurious) begin
          alu_done = 1'b1;
          alu_result = 16'hDEAD;
        end
        tick();
        alu_done = 1'b0;
        waitCycles = timeoutCase ? TO : doneWait;
        for (int k = 1; k <= waitCycles; k++) begin
          #1;
          checkOutput("wait_hold", {alu_start, alu_op, alu_a, alu_b, rsp0_valid, rsp1_valid},
                      {1'b1, op, a, b, 2'b00});
          if (!timeoutCase && (k == doneWait)) begin
            alu_done = 1'b1;
            alu_result = refResult(alu_op, alu_a, alu_b);
          end
          tick();
          alu_done = 1'b0;
        end
      end else begin
        tick();
      end
    end
    #1;
    checkOutput("resp_valid", {rsp1_valid, rsp0_valid}, (w == 1) ? 2'b10 : 2'b01);
    checkOutput("resp_ctrl", {alu_start, busy, req0_ready, req1_ready}, 4'b0100);
    lastW   = w;
    lastRes = (w == 1) ? rsp1_result : rsp0_result;
    lastErr = (w == 1) ? rsp1_err : rsp0_err;
    checkOutput("resp_data", {lastErr, lastRes}, {expErr, expRes});
    tick();
    checkOutput("back_idle", {busy, alu_start, rsp0_valid, rsp1_valid}, 4'b0000);
  endtask

  initial begin
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    pOp[0] = 3'd0; pOp[1] = 3'd0;
    pA[0] = 8'd0; pA[1] = 8'd0;
    pB[0] = 8'd0; pB[1] = 8'd0;
    lastWinner = 1;

    // Reset dominates a pending request.
    setReq(0, 3'd1, 8'h11, 8'h22);
    applyStimulus();
    tick();
    checkOutput("ready_in_reset", {req1_ready, req0_ready}, 2'b00);
    doReset();

    setReq(0, 3'd1, 8'h05, 8'h03);
    runTxn(3, 1'b0);
    checkOutput("add_result", {lastErr, lastRes}, {1'b0, 16'h0008});

    doReset();
    setReq(0, 3'd4, 8'h10, 8'h10);
    setReq(1, 3'd3, 8'hF0, 8'h0F);
    runTxn(2, 1'b0);
    checkOutput("contend_first", {lastW[0], lastRes}, {1'b0, 16'h0100});
    runTxn(1, 1'b0);
    checkOutput("contend_second", {lastW[0], lastRes}, {1'b1, 16'h00FF});
    setReq(0, 3'd2, 8'h3C, 8'h0F);
    setReq(1, 3'd1, 8'hFF, 8'h01);
    runTxn(4, 1'b1);
    checkOutput("contend_again", {lastW[0], lastRes}, {1'b0, 16'h000C});
    runTxn(2, 1'b0);
    checkOutput("carry_out", lastRes, 16'h0100);

    setReq(1, 3'd0, 8'hAA, 8'h55);
    runTxn(1, 1'b0);
    checkOutput("noop_result", {lastW[0], lastErr, lastRes}, {1'b1, 1'b0, 16'h0000});

    setReq(0, 3'd6, 8'h12, 8'h34);
    runTxn(1, 1'b0);
    checkOutput("illegal_err", {lastErr, lastRes}, {1'b1, 16'h0000});

    // Reset while the ALU is busy drops the command with no response.
    setReq(0, 3'd4, 8'hFF, 8'hFF);
    applyStimulus();
    tick();
    pend[0] = 1'b0;
    applyStimulus();
    tick();
    checkOutput("in_wait", {alu_start, busy}, 2'b11);
    reset = 1'b1;
    tick();
    checkAllZero("reset_in_wait");
    reset = 1'b0;
    lastWinner = 1;
    for (int k = 0; k < 3; k++) begin
      alu_done = (k == 0);
      alu_result = 16'hBEEF;
      tick();
      checkOutput("no_rsp_after_reset", {busy, rsp0_valid, rsp1_valid}, 3'b000);
    end
    alu_done = 1'b0;

`ifdef ALU_ARB_TIMEOUT_EN
    setReq(1, 3'd1, 8'h01, 8'h02);
    runTxn(TO + 1, 1'b0);
    checkOutput("timeout_err", {lastErr, lastRes}, {1'b1, 16'h0000});
`endif

    for (int iter = 0; iter < 200; iter++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
          setReq(i, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
      end
      if (pend[0] || pend[1]) begin
        runTxn($urandom_range(1, 5), 1'($urandom_range(0, 1)));
      end else begin
        applyStimulus();
        checkOutput("idle_quiet", {busy, alu_start, req0_ready, req1_ready}, 4'b0000);
        tick();
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
